// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with start/busy/done handshake; one WIDTH+1-bit adder.
// Define SEQ_MULT_SIGNED_EN to treat a, b and p as two's complement.
module seq_mult #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplr_q, mplr_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     p_q, p_d;
  logic              done_q, done_d;

  logic [WIDTH:0]    sum;
  logic [WIDTH:0]    add_hi;
  logic [PW:0]       acc_wide;
  logic [PW-1:0]     acc_shift;
  logic [PW-1:0]     result;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;
  logic              last;

`ifdef SEQ_MULT_SIGNED_EN
  logic sign_q, sign_d;

  // Magnitudes fit unsigned in WIDTH bits, including the most negative value.
  always_comb begin
    a_in   = a[WIDTH-1] ? -a : a;
    b_in   = b[WIDTH-1] ? -b : b;
    result = sign_q ? -acc_shift : acc_shift;
  end
`else
  always_comb begin
    a_in   = a;
    b_in   = b;
    result = acc_shift;
  end
`endif

  // Carry from the add lands in the top bit before the right shift, so it is never lost.
  always_comb begin
    sum       = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, mcand_q};
    add_hi    = mplr_q[0] ? sum : {1'b0, acc_q[PW-1:WIDTH]};
    acc_wide  = {add_hi, acc_q[WIDTH-1:0]};
    acc_shift = PW'(acc_wide >> 1);
    last      = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = a_in;
          mplr_d  = b_in;
          acc_d   = '0;
          cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d  = acc_shift;
        mplr_d = mplr_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (last) begin
          p_d     = result;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign p    = p_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: WIDTH=4 main instance plus a WIDTH=8 instance.
// Expected products come from a reference model honouring SEQ_MULT_SIGNED_EN.
module tb_seq_mult;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  a;
  logic [3:0]  b;
  logic [7:0]  p;
  logic        busy;
  logic        done;

  logic        start8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;
  logic        busy8;
  logic        done8;

  int n_vec;
  int n_err;
  logic [7:0]  exp_q[$];
  logic [15:0] exp8_q[$];

  seq_mult #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  seq_mult #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .p     (p8),
    .busy  (busy8),
    .done  (done8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [3:0] sx;
    logic signed [3:0] sy;
    sx = x;
    sy = y;
    return 8'(int'(sx) * int'(sy));
`else
    return {4'b0, x} * {4'b0, y};
`endif
  endfunction

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    logic signed [7:0] sx;
    logic signed [7:0] sy;
    sx = x;
    sy = y;
    return 16'(int'(sx) * int'(sy));
`else
    return {8'b0, x} * {8'b0, y};
`endif
  endfunction

  // Called at posedge+1 while idle; start is seen by the next edge (T0).
  task automatic pulse_start(input logic [3:0] x, input logic [3:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
    exp_q.push_back(model4(x, y));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done, and samples where busy was high before done.
  task automatic wait_done(output int cyc, output int bcnt, output bit seen);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    start  = 1'b0;
    start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (p !== 8'h00) begin n_err++; $display("FAIL reset_p: got %h want 00", p); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_vec++;
    if (p8 !== 16'h0000) begin n_err++; $display("FAIL reset_p8: got %h want 0000", p8); end
  endtask

  task automatic test_basic;
    logic [3:0] va [6] = '{4'd15, 4'd0, 4'd9, 4'd1, 4'd3, 4'd8};
    logic [3:0] vb [6] = '{4'd15, 4'd9, 4'd1, 4'd15, 4'd5, 4'd7};
    logic [7:0] e;
    int cyc, bcnt;
    bit seen;
    for (int i = 0; i < 6; i++) begin
      pulse_start(va[i], vb[i]);
      wait_done(cyc, bcnt, seen);
      n_vec++;
      if (!seen || cyc != 4) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: got seen=%0b cyc=%0d want cyc=4", i, seen, cyc);
      end
      n_vec++;
      if (bcnt != 4) begin n_err++; $display("FAIL basic_busy[%0d]: got %0d want 4", i, bcnt); end
      e = exp_q.pop_front();
      n_vec++;
      if (p !== e) begin n_err++; $display("FAIL basic_p[%0d]: got %h want %h", i, p, e); end
      @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || p !== e) begin
        n_err++;
        $display("FAIL basic_hold[%0d]: got done=%b p=%h want done=0 p=%h", i, done, p, e);
      end
    end
  endtask

  task automatic test_ignore_restart;
    logic [7:0] e;
    int dcnt, bsy;
    pulse_start(4'd3, 4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd12; b = 4'd9;
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL ignore_busy: got %b want 1", busy); end
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_vec++;
    if (done !== 1'b1 || p !== e) begin
      n_err++;
      $display("FAIL ignore_result: got done=%b p=%h want done=1 p=%h", done, p, e);
    end
    dcnt = 0;
    bsy  = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (busy) bsy++;
    end
    n_vec++;
    if (dcnt != 0 || bsy != 0) begin
      n_err++;
      $display("FAIL ignore_extra: got done=%0d busy=%0d want 0 0", dcnt, bsy);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    int cyc, bcnt;
    bit seen;
    start = 1'b1; a = 4'd2; b = 4'd6;
    exp_q.push_back(model4(4'd2, 4'd6));
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc, bcnt, seen);
      if (k < 2) exp_q.push_back(model4(4'd2, 4'd6));
      else start = 1'b0;
      n_vec++;
      if (!seen || cyc != ((k == 0) ? 4 : 5)) begin
        n_err++;
        $display("FAIL b2b_period[%0d]: got seen=%0b cyc=%0d want %0d", k, seen, cyc,
                 (k == 0) ? 4 : 5);
      end
      n_vec++;
      if (bcnt != 4 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_busy[%0d]: got run=%0d busy=%b want 4 0", k, bcnt, busy);
      end
      e = exp_q.pop_front();
      n_vec++;
      if (p !== e) begin n_err++; $display("FAIL b2b_p[%0d]: got %h want %h", k, p, e); end
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
  endtask

  task automatic test_async_reset;
    logic [7:0] e;
    int cyc, bcnt, dcnt;
    bit seen;
    start = 1'b1; a = 4'd15; b = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (p !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: got p=%h busy=%b done=%b want 00 0 0", p, busy, done);
    end
    #2;
    reset = 1'b0;
    dcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    n_vec++;
    if (dcnt != 0 || p !== 8'h00) begin
      n_err++;
      $display("FAIL async_nodone: got done=%0d p=%h want 0 00", dcnt, p);
    end
    pulse_start(4'd4, 4'd4);
    wait_done(cyc, bcnt, seen);
    e = exp_q.pop_front();
    n_vec++;
    if (!seen || cyc != 4 || p !== e) begin
      n_err++;
      $display("FAIL async_after: got seen=%0b cyc=%0d p=%h want 4 %h", seen, cyc, p, e);
    end
  endtask

  task automatic test_width8;
    logic [15:0] e;
    int cyc;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    exp8_q.push_back(model8(8'hFF, 8'hFF));
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    cyc = 0;
    while (!done8 && cyc < 30) begin
      @(posedge clk); #1;
      cyc++;
    end
    e = exp8_q.pop_front();
    n_vec++;
    if (done8 !== 1'b1 || cyc != 8) begin
      n_err++;
      $display("FAIL w8_latency: got done=%b cyc=%0d want 1 8", done8, cyc);
    end
    n_vec++;
    if (p8 !== e) begin n_err++; $display("FAIL w8_p: got %h want %h", p8, e); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_ignore_restart();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
Parametrised sequential shift-add multiplier with a start/busy/done handshake, replacing the fixed 4x4 combinational multiplier.
- Computes P = A * B over WIDTH iterations using one adder of WIDTH+1 bits.
- Sits between switch/key capture logic and the char_7seg_hex display decoders; the product register drives the displays directly.
- Operands are captured on start, so the switches may change freely while a multiply runs.

Parameters:
- WIDTH, 4, operand width in bits (legal range 2..16); product width is 2*WIDTH.
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request a multiply; sampled only when busy=0.
- a  input  WIDTH  multiplicand; captured on an accepted start.
- b  input  WIDTH  multiplier; captured on an accepted start.
- p  output  2*WIDTH  product register; holds the last result until the next completion.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse, high in the cycle p first shows a new result.

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE; p=0; busy=0; done=0; counter=0; internal accumulator and operand registers cleared. No result is produced for an interrupted multiply.
- States:
  - IDLE: busy=0. A rising edge with start=1 (edge T0) captures mcand=a, mplr=b, acc=0, cnt=0, and moves to RUN.
  - RUN: busy=1. Each edge:
    - if mplr[0]=1, the upper WIDTH+1 bits of acc get acc_hi + mcand;
    - then {carry, acc} shifts right by 1 and mplr shifts right by 1;
    - cnt increments.
  - Completion: at edge T_WIDTH (WIDTH edges after T0), p<=final acc, done<=1, busy<=0, return to IDLE.
- Latency: done is high in the cycle following edge T_WIDTH, i.e. exactly WIDTH cycles after the start-accepting edge.
- Throughput: one result every WIDTH+1 cycles with start held high.
- done is a single-cycle pulse; it deasserts on the next edge regardless of start.
- start while busy=1 is ignored: no restart and no queuing.
- start high in the done cycle is accepted, because busy=0 in that cycle. The new operation begins and p keeps the old result until its own completion.
- Width rules:
  - unsigned operands;
  - the adder is WIDTH+1 bits wide, so the carry-out is never lost;
  - the result is exact over the full range, with no overflow possible in 2*WIDTH bits.
- Operand changes on a/b during RUN do not affect the result.
- Zero operands still take the full WIDTH cycles; there is no early termination.
- p changes only at completion or reset.

Optional Feature:
SEQ_MULT_SIGNED_EN
- Defined: a, b and p are two's complement.
  - On start, the block captures |a| and |b| (|-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits) and registers sign = a[WIDTH-1]^b[WIDTH-1].
  - At completion, p is the two's complement negation of acc when sign=1, otherwise acc.
  - Latency, handshake and reset behaviour are unchanged.
- Undefined: unsigned only; no sign register and no negation logic are synthesised.

Test Plan:
- WIDTH=4, reset high 2 cycles then low; a=15, b=15, start 1 cycle -> busy high 4 cycles; done pulse at cycle 4 after the accepting edge; p=8'hE1 (225), held afterwards.
- WIDTH=4, a=0, b=9, start -> p=0 after exactly 4 cycles; also check a=9, b=1 -> p=9, and a=1, b=15 -> p=15.
- WIDTH=4, start a=3, b=5; pulse start again at cycle 2 with a=7, b=7; change a/b during RUN -> single done, p=15; second start ignored.
- WIDTH=4, start held high continuously with a=2, b=6 -> done every 5 cycles, p=12 each time, and busy=0 only in the done cycles.
- WIDTH=4, start a=15, b=15; assert reset at cycle 2 for a partial cycle (async) -> p=0, busy=0, done=0 immediately, no done pulse follows; the next start a=4, b=4 gives p=16.
- WIDTH=8 with SEQ_MULT_SIGNED_EN: a=8'hFF, b=8'hFF -> p=16'h0001. Also with WIDTH=4: a=4'b1000 (-8), b=7 -> p=8'hC8 (-56), done at cycle 4. Without the macro, WIDTH=8, a=255, b=255 -> p=16'hFE01.
